// File: rtl/axi_write_to_mem_bridge_if.sv
// Signal bundle between an AXI4 write master and the bridge, plus the native memory request bus.
// The bridge uses the slave modport; the traffic source/memory model uses the master modport.
interface axi_write_to_mem_bridge_if #(
    parameter int unsigned AXI_DATA_WIDTH = 512,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_TID_WIDTH  = 8
);
    localparam int unsigned MEM_ADDR_WIDTH = AXI_ADDR_WIDTH - $clog2(AXI_DATA_WIDTH / 8);

    logic                        s_axi_awvalid;
    logic                        s_axi_awready;
    logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [AXI_TID_WIDTH-1:0]    s_axi_awid;
    logic [7:0]                  s_axi_awlen;
    logic [2:0]                  s_axi_awsize;
    logic [1:0]                  s_axi_awburst;
    logic                        s_axi_wvalid;
    logic                        s_axi_wready;
    logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                        s_axi_wlast;
    logic                        s_axi_bvalid;
    logic                        s_axi_bready;
    logic [AXI_TID_WIDTH-1:0]    s_axi_bid;
    logic [1:0]                  s_axi_bresp;
    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic                        mem_req_rw;
    logic [MEM_ADDR_WIDTH-1:0]   mem_req_addr;
    logic [AXI_DATA_WIDTH-1:0]   mem_req_data;
    logic [AXI_DATA_WIDTH/8-1:0] mem_req_byteen;
    logic [AXI_TID_WIDTH-1:0]    mem_req_tag;

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_bready, mem_req_ready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag
    );

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_bready, mem_req_ready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag
    );
endinterface

// File: rtl/axi_write_to_mem_bridge.sv
// AXI4 write-channel slave: one burst at a time, each W beat becomes a memory write request,
// one B response per burst. Unsupported bursts are drained and answered with SLVERR.
module axi_write_to_mem_bridge #(
    parameter int unsigned AXI_DATA_WIDTH = 512,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_TID_WIDTH  = 8
) (
    input logic                      clk,
    input logic                      reset_n,
    axi_write_to_mem_bridge_if.slave bus
);
    localparam int unsigned BYTE_LSB       = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned MEM_ADDR_WIDTH = AXI_ADDR_WIDTH - BYTE_LSB;
    localparam logic [2:0]  FULL_SIZE      = 3'(BYTE_LSB);
    localparam logic [1:0]  BURST_INCR     = 2'b01;

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_TID_WIDTH-1:0]  id_q, id_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic [1:0]                burst_q, burst_d;
    logic                      err_q, err_d;
    logic                      last_err_q, last_err_d;
    logic                      beat;

    // Sub-word address bits carry no information for a full-width beat.
    logic unused_awaddr_lsbs;
    assign unused_awaddr_lsbs = ^bus.s_axi_awaddr[BYTE_LSB-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            last_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            burst_q    <= burst_d;
            err_q      <= err_d;
            last_err_q <= last_err_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        id_d              = id_q;
        len_d             = len_q;
        beat_cnt_d        = beat_cnt_q;
        burst_d           = burst_q;
        err_d             = err_q;
        last_err_d        = last_err_q;
        beat              = 1'b0;
        bus.s_axi_awready = 1'b0;
        bus.s_axi_wready  = 1'b0;
        bus.s_axi_bvalid  = 1'b0;
        bus.mem_req_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.s_axi_awready = 1'b1;
                if (bus.s_axi_awvalid) begin
                    addr_d     = bus.s_axi_awaddr[AXI_ADDR_WIDTH-1:BYTE_LSB];
                    id_d       = bus.s_axi_awid;
                    len_d      = bus.s_axi_awlen;
                    burst_d    = bus.s_axi_awburst;
                    beat_cnt_d = '0;
                    err_d      = bus.s_axi_awburst[1] || (bus.s_axi_awsize != FULL_SIZE);
                    last_err_d = 1'b0;
                    state_d    = StData;
                end
            end
            StData: begin
                // Drain mode swallows beats; otherwise W and the memory bus are wired through.
                if (err_q) begin
                    bus.s_axi_wready = 1'b1;
                end else begin
                    bus.mem_req_valid = bus.s_axi_wvalid;
                    bus.s_axi_wready  = bus.mem_req_ready;
                end
                beat = bus.s_axi_wvalid && (err_q || bus.mem_req_ready);
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (burst_q == BURST_INCR) begin
                        addr_d = addr_q + MEM_ADDR_WIDTH'(1);
                    end
                    // The beat count ends the burst; wlast is only checked against it.
                    if (beat_cnt_q == len_q) begin
                        err_d   = err_q || !bus.s_axi_wlast || last_err_q;
                        state_d = StResp;
                    end else if (bus.s_axi_wlast) begin
                        last_err_d = 1'b1;
                    end
                end
            end
            StResp: begin
                bus.s_axi_bvalid = 1'b1;
                if (bus.s_axi_bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.s_axi_bid      = id_q;
    assign bus.s_axi_bresp    = (state_q == StResp && err_q) ? 2'b10 : 2'b00;
    assign bus.mem_req_rw     = 1'b1;
    assign bus.mem_req_addr   = addr_q;
    assign bus.mem_req_data   = bus.s_axi_wdata;
    assign bus.mem_req_byteen = bus.s_axi_wstrb;
    assign bus.mem_req_tag    = id_q;
endmodule

// File: doc/axi_write_to_mem_bridge.md
Name: axi_write_to_mem_bridge

Overview:
AXI4 write-channel responder (slave) that terminates write bursts from an AXI master, such as the output of the write-channel arbiter. It converts each burst into per-beat write requests on the native memory request bus and returns a single B response per burst. One burst is in flight at a time. AW, W and B are fully handshaked; the memory side needs no write acknowledge.

Parameters:
AXI_DATA_WIDTH, 512, AXI data width in bits; power of two, at least 8.
AXI_ADDR_WIDTH, 32, AXI byte address width.
AXI_TID_WIDTH, 8, AXI ID width; awid is forwarded as mem_req_tag and echoed on bid.
MEM_ADDR_WIDTH, AXI_ADDR_WIDTH-CLOG2(AXI_DATA_WIDTH/8), memory word address width (derived; do not override).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_awaddr  in  AXI_ADDR_WIDTH  byte address
s_axi_awid  in  AXI_TID_WIDTH  transaction ID
s_axi_awlen  in  8  beats minus 1
s_axi_awsize  in  3  bytes per beat, log2
s_axi_awburst  in  2  burst type: 0=FIXED, 1=INCR, 2=WRAP
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_wdata  in  AXI_DATA_WIDTH  write data
s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
s_axi_wlast  in  1  last beat flag
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_bid  out  AXI_TID_WIDTH  echoed ID
s_axi_bresp  out  2  response: 0=OKAY, 2=SLVERR
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory request ready
mem_req_rw  out  1  constant 1 (write)
mem_req_addr  out  MEM_ADDR_WIDTH  word address
mem_req_data  out  AXI_DATA_WIDTH  write data
mem_req_byteen  out  AXI_DATA_WIDTH/8  byte enables
mem_req_tag  out  AXI_TID_WIDTH  equals the latched awid

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; awready=1; wready=0; bvalid=0; bid=0; bresp=0; mem_req_valid=0. The latched address, ID, beat counter and error flag all clear. A reset asserted mid-burst abandons the burst with no B response.
- FSM states: IDLE, DATA, RESP.
- IDLE: awready=1. On awvalid&&awready:
  - Latch addr_q = awaddr[AXI_ADDR_WIDTH-1:CLOG2(AXI_DATA_WIDTH/8)]; unaligned low bits are dropped.
  - Latch id, len, burst. Set beat_cnt=0.
  - err_q = (awburst==WRAP or 3) || (awsize != CLOG2(AXI_DATA_WIDTH/8)).
  - Next state DATA.
- DATA, when err_q=0:
  - mem_req_valid=wvalid; wready=mem_req_ready. This is a combinational pass-through with zero added latency.
  - mem_req_addr=addr_q; mem_req_data=wdata; mem_req_byteen=wstrb; mem_req_tag=id_q.
  - A beat completes on wvalid&&wready. On each beat beat_cnt increments; addr_q increments by 1 for INCR (wrapping modulo 2^MEM_ADDR_WIDTH) and holds for FIXED.
- DATA, when err_q=1 (drain mode): wready=1; mem_req_valid=0. Beats are consumed and discarded.
- Burst end: the beat where beat_cnt==len_q completes the burst; next state RESP.
  - If wlast=0 on that beat, or wlast=1 on any earlier beat, set err_q=1 (sticky).
  - An early wlast does not end the burst; the count is authoritative.
- RESP: bvalid=1; bid=id_q; bresp = err_q ? 2'b10 : 2'b00. Outputs hold stable until bready. On bvalid&&bready the next state is IDLE, and awready rises on the following cycle.
- awready=0 outside IDLE. wready=0 outside DATA. A W beat presented before AW is accepted stalls.
- Minimum burst period is len+3 cycles: AW, len+1 beats, then B. The B response follows the last accepted beat by exactly 1 cycle.
- Simultaneous events: awvalid arriving in RESP stalls until IDLE. bready may be held high early; the handshake occurs on the first cycle of RESP.
- mem_req_ready deassert mid-burst: wready drops in the same cycle and the beat is held.

Test Plan:
- Single beat: awaddr=0x1040, awlen=0, awsize=6, INCR, id=0x5; wstrb=all ones, wlast=1 -> one mem request with addr=0x41 and tag=0x5; next cycle bvalid with bid=0x5, bresp=0.
- INCR 4-beat burst at awaddr=0x100 with mem_req_ready toggling 1,0,1 -> mem addresses 0x4,0x5,0x6,0x7 in order; no beat lost or duplicated; one B with OKAY.
- FIXED 3-beat burst at 0x200 -> three requests, all to addr 0x8, each with its own byteen; bresp=0.
- WRAP burst, awlen=3 -> 4 beats accepted with wready=1 and mem_req_valid never asserted; bresp=2.
- awlen=1 with wlast=1 on beat 0 -> both beats forwarded; bresp=2. Separately, bready held low 5 cycles -> bvalid and bid stable throughout, awready=0 until 1 cycle after the handshake.
- reset_n pulsed low during beat 2 of an 8-beat burst -> outputs return to reset values immediately; no B issued; a new AW is accepted next.
